minimax_uart_tx: RTL
====================

Name: minimax_uart_tx

Overview:
- Memory-mapped UART transmitter on the minimax core's data bus; the synthesizable successor to the simulation-only console at 0xfffffff8.
- Decodes core stores to its register window and buffers bytes in a small FIFO.
- Serializes buffered bytes as 8N1 frames on txd.
- Provides a registered read port for status polling; the system's rdata mux ORs its rdata with RAM data.

Parameters:
- BASE_ADDR, 32'hFFFFFFF0: word-aligned base of the 8-byte register window.
- CLK_DIV, 16: clocks per bit; legal range 2..65535.
- FIFO_DEPTH, 8: transmit FIFO entries; must be a power of two, 2..64.

Ports:
- clk  in  1: core clock; all state updates on rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- addr  in  32: core data address.
- wdata  in  32: core store data.
- wmask  in  4: byte-lane write strobes; nonzero means store.
- rreq  in  1: core load request.
- rdata  out  32: registered read data; zero when the previous cycle was not a load hit.
- txd  out  1: serial output; idles high.
- tx_busy  out  1: high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Register map (word offsets from BASE_ADDR); addr[1:0] ignored; other addresses ignored.
  - +0 TXDATA, write-only. A store with wmask[0]=1 pushes wdata[7:0]. Reads return 0.
  - +4 STATUS, read/write.
    - Read bits: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky), bits[14:8] fifo count (0..FIFO_DEPTH), other bits 0.
    - A store with wmask[0]=1 and wdata[3]=1 clears overflow; all other written bits are ignored.
- Reads
  - rdata latches at the edge where rreq=1 and addr hits; valid the cycle after. One-cycle latency, same as RAM.
  - rdata returns 0 at every other edge.
  - Reads have no side effects.
- FIFO push
  - Accepted at the write edge if count < FIFO_DEPTH, judged on pre-edge count.
  - A push while full is dropped and sets overflow, even if a pop occurs the same edge.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer states
  - IDLE: txd=1. If FIFO non-empty, pop at this edge, load the shift register, go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit bit counter tracks position.
  - STOP: txd=1 for CLK_DIV cycles. At the final STOP cycle, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter
  - Loads CLK_DIV-1 on each state or bit entry and decrements to 0; the transition fires at 0.
  - Frame length is exactly 10*CLK_DIV cycles.
- Latency: a store accepted at edge N with serializer IDLE causes the pop at edge N+1; txd falls after edge N+1.
- txd is driven from a flop; no combinational path from the bus.
- Reset values: txd=1, rdata=0, tx_busy=0, FIFO empty, count=0, overflow=0, state IDLE, baud counter 0.
- Reset mid-frame: txd returns high asynchronously; the partial frame and FIFO contents are discarded.

Decomposition:
- Package minimax_uart_pkg holds:
  - register offsets (TXDATA_OFS=0, STATUS_OFS=4);
  - STATUS bit positions;
  - serializer state encoding (IDLE, START, DATA, STOP);
  - count field width as a function of FIFO_DEPTH.
- Sub-module minimax_sync_fifo: parameterized width/depth, push/pop/full/empty/count, same clk and async reset. It is reusable for a future RX block.

Test Plan:
- Reset then idle 50 cycles -> txd=1, tx_busy=0; STATUS read returns 0x00000002 one cycle after rreq.
- CLK_DIV=4: store 0x55 to TXDATA -> txd low 4 cycles starting after the next edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high stop bit; 40 cycles total; tx_busy drops after the stop bit.
- Store 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; STATUS count reads 2 during frame 1; bits decode to 01,02,03.
- Store 10 bytes (0xA0..0xA9) on consecutive cycles with FIFO_DEPTH=8 -> 8 bytes queued plus 1 in shifter at the first pop, so one byte dropped. Overflow=1; STATUS full asserted; decoded stream is 0xA0..0xA8. Storing 0x8 to STATUS then clears overflow.
- Assert reset during DATA bit 3 of a frame with 2 bytes queued -> txd=1 within the reset cycle, STATUS=0x2 after release, no further frames.
- Load from BASE_ADDR+0, from an address outside the window, and a store with wmask=4'b0010 to TXDATA -> rdata=0 for all three, FIFO count unchanged.

Source files
------------

// File: rtl/minimax_uart_pkg.sv
// Shared definitions for the minimax UART block: register offsets, STATUS layout,
// serializer state encoding and FIFO count sizing.
// No logic; imported by minimax_uart_tx and minimax_sync_fifo users.
package minimax_uart_pkg;

    // Byte offsets inside the 8-byte register window (addr[1:0] ignored).
    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    // STATUS register bit positions.
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 7;   // holds 0..64

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Count must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/minimax_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; push/pop/full/empty/count.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push while full is ignored, pop while empty is ignored.
// Ports: clk, reset (async active-high), push/push_dat, pop/pop_dat, full, empty, count.
module minimax_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Acceptance is judged on the pre-edge count, so a push while full is lost
    // even if a pop frees a slot on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/minimax_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a FIFO, serializer drains it on txd.
// Latency: store at edge N pops at N+1 when idle; rdata valid one cycle after a load hit.
// Backpressure: none on the bus; stores to a full FIFO are dropped and set sticky overflow.
// Ports: clk, reset, addr/wdata/wmask/rreq (core data bus), rdata, txd, tx_busy.
module minimax_uart_tx
    import minimax_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFF0,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rreq,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        tx_busy
);

    localparam int          CW        = cnt_width(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

    // ---------------- bus decode ----------------
    logic        win_hit;
    logic [2:0]  reg_ofs;
    logic        hit_tx;
    logic        hit_st;
    logic        fifo_push;
    logic        ovf_clr;
    logic        overflow;
    logic [31:0] status;
    logic        unused_bits;

    assign win_hit   = (addr[31:3] == BASE_ADDR[31:3]);
    assign reg_ofs   = {addr[2], 2'b00};
    assign hit_tx    = win_hit && (reg_ofs == TXDATA_OFS);
    assign hit_st    = win_hit && (reg_ofs == STATUS_OFS);
    assign fifo_push = hit_tx && wmask[0];
    assign ovf_clr   = hit_st && wmask[0] && wdata[ST_OVF];
    assign unused_bits = ^{addr[1:0], wdata[31:8], wmask[3:1]};

    // ---------------- FIFO ----------------
    logic          fifo_pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    minimax_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       overflow <= 1'b0;
        else if (fifo_push && fifo_full) overflow <= 1'b1;
        else if (ovf_clr)                overflow <= 1'b0;
    end

    always_comb begin
        status                               = '0;
        status[ST_FULL]                      = fifo_full;
        status[ST_EMPTY]                     = fifo_empty;
        status[ST_BUSY]                      = tx_busy;
        status[ST_OVF]                       = overflow;
        status[ST_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(fifo_cnt);
    end

    // Zero on every non-hit edge so the system can OR this with RAM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  rdata <= '0;
        else if (rreq && hit_st)    rdata <= status;
        else                        rdata <= '0;
    end

    // ---------------- serializer ----------------
    tx_state_t   state, state_nxt;
    logic [15:0] baud, baud_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic        txd_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            txd     <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        fifo_pop  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sh_nxt    = fifo_dat;
                    baud_nxt  = BAUD_LOAD;
                    state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (baud == '0) begin
                    baud_nxt  = BAUD_LOAD;
                    bit_nxt   = '0;
                    state_nxt = TX_DATA;
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud == '0) begin
                    baud_nxt = BAUD_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = TX_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        sh_nxt  = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        sh_nxt    = fifo_dat;
                        baud_nxt  = BAUD_LOAD;
                        state_nxt = TX_START;
                    end else begin
                        baud_nxt  = '0;
                        state_nxt = TX_IDLE;
                    end
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // txd is registered from the next-state view so it changes on the same
    // edge as the state, with no bus-to-pin combinational path.
    always_comb begin
        txd_nxt = 1'b1;
        if (state_nxt == TX_START)     txd_nxt = 1'b0;
        else if (state_nxt == TX_DATA) txd_nxt = sh_nxt[0];
        tx_busy = (state != TX_IDLE) || !fifo_empty;
    end

endmodule
